// File: rtl/inst_sequencer_pkg.sv
// inst_sequencer_pkg: shared widths, instruction field positions and FSM encodings
package inst_sequencer_pkg;
  localparam int INST_WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int REP_W = 16;
  localparam int OUT_W = 4;
  localparam int REP_LSB = 32;
  localparam int REP_MSB = 47;
  localparam int OPCODE_LSB = 29;
  localparam int OPCODE_MSB = 31;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_ISSUE = ST_ISSUE,
    S_DRAIN = ST_DRAIN,
    S_DONE = ST_DONE
  } state_e;
  // A repeat field of zero still issues the instruction once.
  function automatic logic [REP_W-1:0] rep_count(input logic [INST_WIDTH-1:0] w);
    return (w[REP_MSB:REP_LSB] == '0) ? REP_W'(1) : w[REP_MSB:REP_LSB];
  endfunction
endpackage

// File: rtl/inst_sequencer_mem.sv
// inst_sequencer_mem: program register file, synchronous write, asynchronous read
module inst_sequencer_mem
  import inst_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [INST_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [INST_WIDTH-1:0] rdata_o
);
  logic [INST_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: issues a stored program with per-instruction repeat and tracks outstanding write-backs
module inst_sequencer
  import inst_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [INST_WIDTH-1:0] prog_data,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_inst,
  input  logic                  hold,
  input  logic                  wb_v,
  output logic                  inst_v,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d, rdata;
  logic busy_q, busy_d, err_q, err_d;
  logic issue, unf, ovf, start_ok;

  inst_sequencer_mem u_mem (
    .clk(clk),
    .we_i(prog_we && state_q == S_IDLE),
    .waddr_i(prog_addr),
    .wdata_i(prog_data),
    .raddr_i(pc_q),
    .rdata_o(rdata)
  );

  assign issue = state_q == S_ISSUE && !hold;
  assign start_ok = state_q == S_IDLE && start;
  assign unf = wb_v && !issue && out_q == '0;
  assign ovf = issue && !wb_v && &out_q;
  // Underflow and overflow both pin the counter and flag the error.
  assign out_d = (issue == wb_v || unf || ovf) ? out_q : issue ? out_q + OUT_W'(1) : out_q - OUT_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    len_d = len_q;
    rep_d = rep_q;
    inst_d = inst_q;
    busy_d = busy_q;
    err_d = (err_q && !start_ok) || unf || ovf;
    case (state_q)
      S_IDLE: if (start) begin
        len_d = num_inst;
        pc_d = '0;
        busy_d = 1'b1;
        state_d = (num_inst == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        inst_d = rdata;
        rep_d = rep_count(rdata);
        state_d = S_ISSUE;
      end
      S_ISSUE: if (!hold) begin
        if (rep_q > REP_W'(1)) rep_d = rep_q - REP_W'(1);
        else if ({1'b0, pc_q} < len_q - (ADDR_W+1)'(1)) begin
          pc_d = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else state_d = S_DRAIN;
      end
      S_DRAIN: state_d = (out_d == '0) ? S_DONE : S_DRAIN;
      S_DONE: begin
        busy_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      len_q <= '0;
      rep_q <= '0;
      out_q <= '0;
      inst_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      len_q <= len_d;
      rep_q <= rep_d;
      out_q <= out_d;
      inst_q <= inst_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end

  assign inst_v = issue;
  assign inst = inst_q;
  assign busy = busy_q;
  assign done = state_q == S_DONE;
  assign err = err_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: table-driven, directed and randomized checks against a queue-based program model
module tb_inst_sequencer;
  import inst_sequencer_pkg::*;
  logic clk = 1'b0, rst = 1'b1, prog_we = 1'b0, start = 1'b0, hold = 1'b0, wb_force = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [INST_WIDTH-1:0] prog_data = '0;
  logic [ADDR_W:0] num_inst = '0;
  logic wb_v, inst_v, busy, done, err;
  logic [INST_WIDTH-1:0] inst;
  logic [5:0] wb_pipe;
  logic [INST_WIDTH-1:0] model_mem [DEPTH];
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic st;
    logic ev;
    int   sel;
    logic eb;
    logic ed;
  } vec_t;
  vec_t tv [15];

  always #5 clk = ~clk;
  // Decoder stand-in: every issued instruction writes back six cycles later.
  always @(posedge clk) wb_pipe <= rst ? 6'd0 : {wb_pipe[4:0], inst_v};
  assign wb_v = wb_pipe[5] | wb_force;

  inst_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .num_inst(num_inst), .hold(hold), .wb_v(wb_v),
    .inst_v(inst_v), .inst(inst), .busy(busy), .done(done), .err(err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] mk(input int op, input int rep, input int lo);
    logic [63:0] w;
    w = '0;
    w[28:0] = 29'(lo);
    w[OPCODE_MSB:OPCODE_LSB] = 3'(op);
    w[REP_MSB:REP_LSB] = 16'(rep);
    return w;
  endfunction

  function automatic logic [63:0] rnd_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[REP_MSB:REP_LSB] = 16'($urandom_range(0, 4));
    return w;
  endfunction

  function automatic int rep_of(input logic [63:0] w);
    return (w[REP_MSB:REP_LSB] == 16'd0) ? 1 : int'(w[REP_MSB:REP_LSB]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; prog_we = 1'b0; start = 1'b0; hold = 1'b0; wb_force = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input int a, input logic [63:0] w);
    prog_we = 1'b1;
    prog_addr = ADDR_W'(a);
    prog_data = w;
    model_mem[a] = w;
    tick();
    prog_we = 1'b0;
  endtask

  // Expected issue stream is the program flattened by repeat count; a new
  // instruction costs one fetch bubble; done follows the last write-back.
  task automatic run_prog(input int n, input int hpct, input int hf, input int hl,
                          input int mpct, input int amax, output int iss);
    logic [63:0] qw[$];
    int qi[$];
    int wait_c, issued, retired, done_at, idx;
    logic hd, ev, drain, fin;
    logic [63:0] ew;
    iss = 0; issued = 0; retired = 0; fin = 1'b0; ew = '0;
    wait_c = (n == 0) ? 0 : 1;
    done_at = (n == 0) ? 1 : -1;
    for (int i = 0; i < n; i++)
      for (int r = 0; r < rep_of(model_mem[i]); r++) begin
        qw.push_back(model_mem[i]);
        qi.push_back(i);
      end
    for (int k = 0; k < 400 && !fin; k++) begin
      if (k > 0) tick();
      hd = (k >= hf && k < hf + hl) || ($urandom_range(0, 99) < hpct);
      hold = hd;
      prog_we = 1'b0;
      start = (k == 0);
      if (k == 0) num_inst = (ADDR_W+1)'(n);
      else if ((done_at < 0 || k <= done_at) && $urandom_range(0, 99) < mpct) begin
        start = 1'b1;
        num_inst = (ADDR_W+1)'($urandom_range(0, 16));
        prog_we = 1'b1;
        prog_addr = ADDR_W'($urandom_range(0, amax));
        prog_data = {$urandom, $urandom};
      end
      @(negedge clk);
      ev = 1'b0; drain = 1'b0;
      if (k > 0) begin
        if (wait_c > 0) wait_c--;
        else if (qw.size() > 0) begin
          if (!hd) begin
            ev = 1'b1;
            ew = qw.pop_front();
            idx = qi.pop_front();
            issued++;
            if (qi.size() > 0 && qi[0] != idx) wait_c = 1;
          end
        end else drain = 1'b1;
      end
      chk($sformatf("run n=%0d k=%0d inst_v", n, k), 64'(inst_v), 64'(ev));
      chk($sformatf("run n=%0d k=%0d busy", n, k), 64'(busy), 64'(k > 0 && (done_at < 0 || k <= done_at)));
      chk($sformatf("run n=%0d k=%0d done", n, k), 64'(done), 64'(k == done_at));
      if (k > 0) chk($sformatf("run n=%0d k=%0d err", n, k), 64'(err), 64'(0));
      if (ev) chk($sformatf("run n=%0d k=%0d inst", n, k), inst, ew);
      if (inst_v) iss++;
      if (wb_v) retired++;
      if (drain && done_at < 0 && retired == issued) done_at = k + 1;
      fin = done_at > 0 && k == done_at + 1;
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: n=%0d got no completion, want done within 400 cycles", n);
      do_reset();
    end else tick();
    prog_we = 1'b0; start = 1'b0; hold = 1'b0;
  endtask

  initial begin
    logic [14:0] ev_m, b_m, d_m;
    int iss;
    tick();
    @(negedge clk);
    chk("reset inst_v", 64'(inst_v), 64'(0));
    chk("reset inst", inst, 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset err", 64'(err), 64'(0));
    tick();
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) load(a, rnd_word());

    // Three single-shot instructions: issues on cycles 2,4,6, write-backs 8,10,12, done 13.
    load(0, mk(1, 1, 'h11));
    load(1, mk(2, 1, 'h22));
    load(2, mk(3, 1, 'h33));
    num_inst = 5'd3;
    ev_m = 15'h0054;
    b_m = 15'h3FFE;
    d_m = 15'h2000;
    for (int k = 0; k < 15; k++) tv[k] = '{st: k == 0, ev: ev_m[k], sel: (k - 2) / 2, eb: b_m[k], ed: d_m[k]};
    for (int k = 0; k < 15; k++) begin
      if (k > 0) tick();
      start = tv[k].st;
      hold = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl k=%0d inst_v", k), 64'(inst_v), 64'(tv[k].ev));
      chk($sformatf("tbl k=%0d busy", k), 64'(busy), 64'(tv[k].eb));
      chk($sformatf("tbl k=%0d done", k), 64'(done), 64'(tv[k].ed));
      if (k > 0) chk($sformatf("tbl k=%0d err", k), 64'(err), 64'(0));
      if (tv[k].ev) chk($sformatf("tbl k=%0d inst", k), inst, model_mem[tv[k].sel]);
    end
    tick();
    start = 1'b0;

    load(0, mk(4, 4, 'h44));
    run_prog(1, 0, -1, 0, 0, 0, iss);
    chk("rep4 issues", 64'(iss), 64'(4));

    load(0, mk(2, 3, 'h55));
    run_prog(1, 0, 3, 3, 0, 0, iss);
    chk("hold rep3 issues", 64'(iss), 64'(3));

    run_prog(0, 0, -1, 0, 0, 0, iss);
    chk("empty issues", 64'(iss), 64'(0));
    wb_force = 1'b1;
    tick();
    wb_force = 1'b0;
    @(negedge clk);
    chk("stray wb err", 64'(err), 64'(1));
    tick();
    run_prog(1, 0, -1, 0, 0, 0, iss);

    // Reset while draining with two write-backs still in flight.
    load(0, mk(1, 1, 'h66));
    load(1, mk(2, 1, 'h77));
    num_inst = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("drain busy", 64'(busy), 64'(1));
    chk("drain inst_v", 64'(inst_v), 64'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("post rst %0d busy", i), 64'(busy), 64'(0));
      chk($sformatf("post rst %0d inst_v", i), 64'(inst_v), 64'(0));
      chk($sformatf("post rst %0d done", i), 64'(done), 64'(0));
      chk($sformatf("post rst %0d err", i), 64'(err), 64'(0));
      tick();
    end
    run_prog(2, 0, -1, 0, 0, 0, iss);

    // Writes to address 0 while busy must not land; the next run reads it back.
    run_prog(2, 0, -1, 0, 100, 0, iss);
    run_prog(2, 0, -1, 0, 0, 0, iss);

    for (int it = 0; it < 30; it++) begin
      for (int j = 0; j < $urandom_range(1, 4); j++) load($urandom_range(0, DEPTH - 1), rnd_word());
      run_prog($urandom_range(0, 6), $urandom_range(0, 40), -1, 0, 10, DEPTH - 1, iss);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
